// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - tiles operand vectors and skews lane k by k cycles for the systolic array
// Optional: define SKEW_FEEDER_ZERO_PAD_EN to read lanes as zero whenever their valid is low.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 4,
  parameter int TILE_LEN   = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_o,
  output logic [NUM_LANES-1:0]            lane_valid_o,
  output logic [NUM_LANES-1:0]            lane_clr_o,
  output logic                            busy_o,
  output logic                            tile_done_o
);

  localparam int BW = $clog2(TILE_LEN + 1);
  localparam int FW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [BW-1:0] BEAT_ONE   = BW'(1);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(TILE_LEN - 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            accept;
  logic            first_beat;
  logic            tile_done;

  assign in_ready_o  = (state_q != FLUSH) && !clear_i;
  assign accept      = in_valid_i && in_ready_o;
  assign first_beat  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign tile_done_o = tile_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // clear_i overrides everything, including the done pulse of a finishing tile.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    tile_done   = 1'b0;
    if (clear_i) begin
      state_d     = IDLE;
      beat_cnt_d  = '0;
      flush_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            beat_cnt_d = BEAT_ONE;
            if (TILE_LEN == 1) begin
              state_d     = FLUSH;
              flush_cnt_d = FLUSH_INIT;
            end else begin
              state_d = STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            beat_cnt_d = beat_cnt_q + BEAT_ONE;
            if (beat_cnt_q == BEAT_LAST) begin
              state_d     = FLUSH;
              flush_cnt_d = FLUSH_INIT;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_q == '0) begin
            tile_done  = 1'b1;
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - FW'(1);
          end
        end
        default: begin
          state_d     = IDLE;
          beat_cnt_d  = '0;
          flush_cnt_d = '0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] data_q [0:k];
    logic                  vld_q  [0:k];
    logic                  clr_q  [0:k];

    // Data only advances behind a valid beat, so an idle lane holds its last operand.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s <= k; s++) begin
          vld_q[s]  <= 1'b0;
          clr_q[s]  <= 1'b0;
          data_q[s] <= '0;
        end
      end else if (clear_i) begin
        for (int s = 0; s <= k; s++) begin
          vld_q[s] <= 1'b0;
          clr_q[s] <= 1'b0;
        end
      end else begin
        vld_q[0] <= accept;
        clr_q[0] <= accept && first_beat;
        if (accept) begin
          data_q[0] <= in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int s = 1; s <= k; s++) begin
          vld_q[s] <= vld_q[s-1];
          clr_q[s] <= clr_q[s-1];
          if (vld_q[s-1]) begin
            data_q[s] <= data_q[s-1];
          end
        end
      end
    end

`ifdef SKEW_FEEDER_ZERO_PAD_EN
    assign lane_data_o[k*DATA_WIDTH +: DATA_WIDTH] = vld_q[k] ? data_q[k] : '0;
`else
    assign lane_data_o[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
`endif
    assign lane_valid_o[k] = vld_q[k];
    assign lane_clr_o[k]   = clr_q[k];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed-vector bench for systolic_skew_feeder (4 lanes, tile of 3)
module tb_systolic_skew_feeder;

  localparam int DW = 16;
  localparam int NL = 4;
  localparam int TL = 3;
`ifdef SKEW_FEEDER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  localparam logic [63:0] V0 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] V1 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] V2 = 64'h000C_000B_000A_0009;
  localparam logic [63:0] U0 = 64'h0014_0013_0012_0011;
  localparam logic [63:0] U1 = 64'h0018_0017_0016_0015;
  localparam logic [63:0] U2 = 64'h001C_001B_001A_0019;
  localparam logic [63:0] W0 = 64'h0024_0023_0022_0021;
  localparam logic [63:0] W1 = 64'h0028_0027_0026_0025;
  localparam logic [63:0] W2 = 64'h002C_002B_002A_0029;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic [NL*DW-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [NL*DW-1:0]  lane_data;
  logic [NL-1:0]     lane_valid;
  logic [NL-1:0]     lane_clr;
  logic              busy;
  logic              tile_done;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    row_idx  = 0;
  string phase    = "";

  logic [DW-1:0] acc [NL];

  systolic_skew_feeder #(
    .DATA_WIDTH(DW),
    .NUM_LANES (NL),
    .TILE_LEN  (TL)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .lane_data_o (lane_data),
    .lane_valid_o(lane_valid),
    .lane_clr_o  (lane_clr),
    .busy_o      (busy),
    .tile_done_o (tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-lane accumulator standing in for a mac_pe: restarts on clr, adds on valid.
  always @(negedge clk) begin
    for (int k = 0; k < NL; k++) begin
      if (lane_valid[k]) begin
        acc[k] <= lane_clr[k] ? lane_data[k*DW +: DW] : acc[k] + lane_data[k*DW +: DW];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input logic [3:0] vld, input logic [3:0] lclr, input logic rdy,
                               input logic bsy, input logic done, input logic [63:0] dat,
                               input logic [3:0] dm);
    logic [63:0] m;
    logic [63:0] e;
    for (int k = 0; k < NL; k++) begin
      m[k*DW +: DW] = (PAD || dm[k]) ? 16'hFFFF : 16'h0000;
      e[k*DW +: DW] = (PAD && !vld[k]) ? 16'h0000 : dat[k*DW +: DW];
    end
    check_eq($sformatf("%s%0d.valid", phase, row_idx), 64'(lane_valid), 64'(vld));
    check_eq($sformatf("%s%0d.clr", phase, row_idx), 64'(lane_clr), 64'(lclr));
    check_eq($sformatf("%s%0d.ready", phase, row_idx), 64'(in_ready), 64'(rdy));
    check_eq($sformatf("%s%0d.busy", phase, row_idx), 64'(busy), 64'(bsy));
    check_eq($sformatf("%s%0d.done", phase, row_idx), 64'(tile_done), 64'(done));
    check_eq($sformatf("%s%0d.data", phase, row_idx), lane_data & m, e & m);
  endtask

  // Apply inputs ahead of an edge, then check the cycle that follows it.
  task automatic row(input logic iv, input logic cl, input logic [63:0] din,
                     input logic [3:0] vld, input logic [3:0] lclr, input logic rdy,
                     input logic bsy, input logic done, input logic [63:0] dat,
                     input logic [3:0] dm);
    in_valid = iv;
    clear    = cl;
    in_data  = din;
    @(posedge clk);
    #1;
    check_outputs(vld, lclr, rdy, bsy, done, dat, dm);
    row_idx++;
  endtask

  task automatic start_phase(input string name);
    phase   = name;
    row_idx = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    start_phase("reset");
    check_outputs(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 64'h0, 4'hF);

    start_phase("b2b");
    row(1, 0, V0, 4'h1, 4'h1, 1, 1, 0, 64'h0000_0000_0000_0001, 4'hF);
    row(1, 0, V1, 4'h3, 4'h2, 1, 1, 0, 64'h0000_0000_0002_0005, 4'hF);
    row(1, 0, V2, 4'h7, 4'h4, 0, 1, 0, 64'h0000_0003_0006_0009, 4'hF);
    row(0, 0, '0, 4'hE, 4'h8, 0, 1, 0, 64'h0004_0007_000A_0009, 4'hF);
    row(0, 0, '0, 4'hC, 4'h0, 0, 1, 0, 64'h0008_000B_000A_0009, 4'hF);
    row(0, 0, '0, 4'h8, 4'h0, 0, 1, 1, 64'h000C_000B_000A_0009, 4'hF);
    row(0, 0, '0, 4'h0, 4'h0, 1, 0, 0, 64'h000C_000B_000A_0009, 4'hF);

    start_phase("bubble");
    row(1, 0, V0, 4'h1, 4'h1, 1, 1, 0, 64'h000C_000B_000A_0001, 4'hF);
    row(0, 0, '0, 4'h2, 4'h2, 1, 1, 0, 64'h000C_000B_0002_0001, 4'hF);
    row(1, 0, V1, 4'h5, 4'h4, 1, 1, 0, 64'h000C_0003_0002_0005, 4'hF);
    row(1, 0, V2, 4'hB, 4'h8, 0, 1, 0, 64'h0004_0003_0006_0009, 4'hF);
    row(0, 0, '0, 4'h6, 4'h0, 0, 1, 0, 64'h0004_0007_000A_0009, 4'hF);
    row(0, 0, '0, 4'hC, 4'h0, 0, 1, 0, 64'h0008_000B_000A_0009, 4'hF);
    row(0, 0, '0, 4'h8, 4'h0, 0, 1, 1, 64'h000C_000B_000A_0009, 4'hF);
    row(0, 0, '0, 4'h0, 4'h0, 1, 0, 0, 64'h000C_000B_000A_0009, 4'hF);

    start_phase("abort");
    row(1, 0, V0, 4'h1, 4'h1, 1, 1, 0, 64'h000C_000B_000A_0001, 4'hF);
    row(1, 0, V1, 4'h3, 4'h2, 1, 1, 0, 64'h000C_000B_0002_0005, 4'hF);
    row(1, 1, V2, 4'h0, 4'h0, 0, 0, 0, 64'h0000_0000_0000_0005, 4'h1);
    row(1, 0, U0, 4'h1, 4'h1, 1, 1, 0, 64'h0000_0000_0000_0011, 4'h1);
    row(1, 0, U1, 4'h3, 4'h2, 1, 1, 0, 64'h0000_0000_0012_0015, 4'h3);
    row(1, 0, U2, 4'h7, 4'h4, 0, 1, 0, 64'h0000_0013_0016_0019, 4'h7);
    row(0, 0, '0, 4'hE, 4'h8, 0, 1, 0, 64'h0014_0017_001A_0019, 4'hF);
    row(0, 0, '0, 4'hC, 4'h0, 0, 1, 0, 64'h0018_001B_001A_0019, 4'hF);
    row(0, 0, '0, 4'h8, 4'h0, 0, 1, 1, 64'h001C_001B_001A_0019, 4'hF);
    row(0, 0, '0, 4'h0, 4'h0, 1, 0, 0, 64'h001C_001B_001A_0019, 4'hF);

    start_phase("areset");
    row(1, 0, V0, 4'h1, 4'h1, 1, 1, 0, 64'h001C_001B_001A_0001, 4'hF);
    row(1, 0, V1, 4'h3, 4'h2, 1, 1, 0, 64'h001C_001B_0002_0005, 4'hF);
    row(1, 0, V2, 4'h7, 4'h4, 0, 1, 0, 64'h001C_0003_0006_0009, 4'hF);
    row(0, 0, '0, 4'hE, 4'h8, 0, 1, 0, 64'h0004_0007_000A_0009, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 64'h0, 4'hF);
    #2;
    rst_n = 1'b1;

    start_phase("two_tiles");
    row(1, 0, V0, 4'h1, 4'h1, 1, 1, 0, 64'h0000_0000_0000_0001, 4'hF);
    row(1, 0, V1, 4'h3, 4'h2, 1, 1, 0, 64'h0000_0000_0002_0005, 4'hF);
    row(1, 0, V2, 4'h7, 4'h4, 0, 1, 0, 64'h0000_0003_0006_0009, 4'hF);
    row(0, 0, '0, 4'hE, 4'h8, 0, 1, 0, 64'h0004_0007_000A_0009, 4'hF);
    row(0, 0, '0, 4'hC, 4'h0, 0, 1, 0, 64'h0008_000B_000A_0009, 4'hF);
    row(0, 0, '0, 4'h8, 4'h0, 0, 1, 1, 64'h000C_000B_000A_0009, 4'hF);
    row(1, 0, W0, 4'h0, 4'h0, 1, 0, 0, 64'h000C_000B_000A_0009, 4'hF);
    row(1, 0, W0, 4'h1, 4'h1, 1, 1, 0, 64'h000C_000B_000A_0021, 4'hF);
    row(1, 0, W1, 4'h3, 4'h2, 1, 1, 0, 64'h000C_000B_0022_0025, 4'hF);
    row(1, 0, W2, 4'h7, 4'h4, 0, 1, 0, 64'h000C_0023_0026_0029, 4'hF);
    row(0, 0, '0, 4'hE, 4'h8, 0, 1, 0, 64'h0024_0027_002A_0029, 4'hF);
    row(0, 0, '0, 4'hC, 4'h0, 0, 1, 0, 64'h0028_002B_002A_0029, 4'hF);
    row(0, 0, '0, 4'h8, 4'h0, 0, 1, 1, 64'h002C_002B_002A_0029, 4'hF);
    row(0, 0, '0, 4'h0, 4'h0, 1, 0, 0, 64'h002C_002B_002A_0029, 4'hF);

    check_eq("acc0", 64'(acc[0]), 64'h6F);
    check_eq("acc1", 64'(acc[1]), 64'h72);
    check_eq("acc2", 64'(acc[2]), 64'h75);
    check_eq("acc3", 64'(acc[3]), 64'h78);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
